// File: rtl/ddr_port_write_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : ddr_arb_pkg
// Brief  : Shared MIG port types and constants (states, command codes, burst max)
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ddr_arb_pkg;

    localparam int unsigned BL_MAX_DEFAULT = 64;

    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0] MIG_CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_DATA = 3'd2,
        ST_CMD  = 3'd3,
        ST_DONE = 3'd4
    } arb_state_t;

    function automatic logic [6:0] sat_len(input logic [6:0] len, input logic [6:0] lim);
        return (len > lim) ? lim : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_port_write_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : ddr_port_write_arbiter_if
// Brief  : Requester-side and MIG port-0 write signals of the write arbiter
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ddr_port_write_arbiter_if #(
    parameter int ADDR_W = 30
);
    logic [1:0]          req_valid;
    logic [2*ADDR_W-1:0] req_addr;
    logic [13:0]         req_len;
    logic [63:0]         req_data;
    logic [1:0]          req_pop;
    logic [1:0]          req_done;
    logic [1:0]          grant;
    logic                busy;
    logic                mem_calib_done;
    logic                wr_full;
    logic                cmd_full;
    logic                wr_en;
    logic [31:0]         wr_data;
    logic [3:0]          wr_mask;
    logic                cmd_en;
    logic [2:0]          cmd_instr;
    logic [5:0]          cmd_bl;
    logic [ADDR_W-1:0]   cmd_byte_addr;

    // Arbiter side
    modport master (
        input  req_valid, req_addr, req_len, req_data,
        input  mem_calib_done, wr_full, cmd_full,
        output req_pop, req_done, grant, busy,
        output wr_en, wr_data, wr_mask,
        output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr
    );

    // Requesters plus MIG port
    modport slave (
        output req_valid, req_addr, req_len, req_data,
        output mem_calib_done, wr_full, cmd_full,
        input  req_pop, req_done, grant, busy,
        input  wr_en, wr_data, wr_mask,
        input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr
    );
endinterface

`default_nettype wire

// File: rtl/ddr_port_write_arbiter_rr_pick2.sv
//------------------------------------------------------------------------------
// Module : rr_pick2
// Brief  : Combinational two-way round-robin picker, one-hot grant
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick2 (
    input  wire logic [1:0] valid,
    input  wire logic       last,
    output logic [1:0]      grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ddr_port_write_arbiter.sv
//------------------------------------------------------------------------------
// Module : ddr_port_write_arbiter
// Brief  : Round-robin per-burst sharing of one MIG write port by two requesters
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ddr_port_write_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int BL_MAX = BL_MAX_DEFAULT,
    parameter int ADDR_W = 30
) (
    input  wire logic               clk,
    input  wire logic               reset,
    ddr_port_write_arbiter_if.master bus
);

    localparam logic [6:0] c_LEN_MAX = 7'(BL_MAX);

    arb_state_t          r_state;
    logic [1:0]          r_grant;
    logic                r_gidx;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [6:0]          r_len;
    logic [6:0]          r_cnt;
    logic                r_cmd_en;
    logic [5:0]          r_cmd_bl;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [1:0]          r_done;
    logic                r_busy;

    logic [1:0]          w_pick;
    logic                w_pick_idx;
    logic [ADDR_W-1:0]   w_addr_sel;
    logic [6:0]          w_len_sel;
    logic [6:0]          w_len_sat;
    logic                w_push;
    logic                w_last_push;

    rr_pick2 u_pick (
        .valid (bus.req_valid),
        .last  (r_last),
        .grant (w_pick)
    );

    assign w_pick_idx  = w_pick[1];
    assign w_addr_sel  = w_pick_idx ? bus.req_addr[ADDR_W +: ADDR_W] : bus.req_addr[0 +: ADDR_W];
    assign w_len_sel   = w_pick_idx ? bus.req_len[13:7] : bus.req_len[6:0];
    assign w_len_sat   = sat_len(w_len_sel, c_LEN_MAX);
    assign w_push      = (r_state == ST_DATA) && !bus.wr_full;
    assign w_last_push = w_push && ((r_cnt + 7'd1) == r_len);

    assign bus.wr_en         = w_push;
    assign bus.req_pop       = w_push ? (r_gidx ? 2'b10 : 2'b01) : 2'b00;
    assign bus.wr_data       = w_push ? (r_gidx ? bus.req_data[63:32] : bus.req_data[31:0]) : 32'd0;
    assign bus.wr_mask       = 4'd0;
    assign bus.cmd_instr     = MIG_CMD_WRITE;
    assign bus.cmd_en        = r_cmd_en;
    assign bus.cmd_bl        = r_cmd_bl;
    assign bus.cmd_byte_addr = r_cmd_addr;
    assign bus.req_done      = r_done;
    assign bus.grant         = r_grant;
    assign bus.busy          = r_busy;

    // The command FIFO is filled only by this block, so a cmd_full low seen
    // one cycle before the registered cmd_en cannot turn high underneath it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= 2'b00;
            r_gidx     <= 1'b0;
            r_last     <= 1'b1;
            r_addr     <= '0;
            r_len      <= 7'd0;
            r_cnt      <= 7'd0;
            r_cmd_en   <= 1'b0;
            r_cmd_bl   <= 6'd0;
            r_cmd_addr <= '0;
            r_done     <= 2'b00;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_calib_done) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (|bus.req_valid) begin
                        r_grant <= w_pick;
                        r_gidx  <= w_pick_idx;
                        r_addr  <= {w_addr_sel[ADDR_W-1:2], 2'b00};
                        r_len   <= w_len_sat;
                        r_cnt   <= 7'd0;
                        r_busy  <= 1'b1;
                        if (w_len_sat == 7'd0) begin
                            r_done  <= w_pick;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_push) begin
                        r_cnt <= r_cnt + 7'd1;
                        if (w_last_push) begin
                            r_state    <= ST_CMD;
                            r_cmd_en   <= !bus.cmd_full;
                            r_cmd_bl   <= 6'(r_len - 7'd1);
                            r_cmd_addr <= r_addr;
                        end
                    end
                end
                ST_CMD: begin
                    if (r_cmd_en) begin
                        r_cmd_en <= 1'b0;
                        r_done   <= r_grant;
                        r_state  <= ST_DONE;
                    end else if (!bus.cmd_full) begin
                        r_cmd_en <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 2'b00;
                    r_grant <= 2'b00;
                    r_last  <= r_gidx;
                    r_busy  <= 1'b0;
                    r_state <= ST_ARB;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr_port_write_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_ddr_port_write_arbiter
// Brief  : Directed self-checking bench for ddr_port_write_arbiter
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ddr_port_write_arbiter;
    import ddr_arb_pkg::*;

    localparam int c_AW = 30;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ddr_port_write_arbiter_if #(.ADDR_W(c_AW)) bus ();

    ddr_port_write_arbiter #(.BL_MAX(64), .ADDR_W(c_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]      valid;
        logic [c_AW-1:0] a0;
        logic [c_AW-1:0] a1;
        logic [6:0]      l0;
        logic [6:0]      l1;
        logic [1:0]      eg;
        int              ep;
        int              ec;
        logic [5:0]      ebl;
        logic [c_AW-1:0] ea;
    } vec_t;

    vec_t vecs [8];

    int n_checks = 0;
    int n_fail   = 0;

    int ncyc = 0;
    int pushes, cmds, pushes_at_cmd, done_cyc, data_err, full_push_err, cmd_full_err;
    int first_push_at, cmd_at, done_at;
    int pop_cnt [2];
    int popped  [2];
    logic [1:0]      done_bits, first_grant;
    logic [5:0]      last_bl;
    logic [c_AW-1:0] last_addr;

    function automatic logic [31:0] word(input int i, input int k);
        return {(i == 1) ? 16'hB00B : 16'hA00A, k[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic clr();
        pushes = 0; cmds = 0; pushes_at_cmd = -1; done_cyc = 0; data_err = 0;
        full_push_err = 0; cmd_full_err = 0; first_push_at = -1; cmd_at = -1; done_at = -1;
        pop_cnt[0] = 0; pop_cnt[1] = 0; done_bits = 2'b00; first_grant = 2'b00;
        last_bl = 6'h3F; last_addr = '1;
    endtask

    // One clock: apply backpressure and FWFT data after the edge, then sample.
    task automatic cyc(input logic wf, input logic cf);
        @(posedge clk);
        #1;
        bus.wr_full  = wf;
        bus.cmd_full = cf;
        bus.req_data = {word(1, popped[1]), word(0, popped[0])};
        #1;
        ncyc++;
        if (bus.wr_en) begin
            pushes++;
            if (first_push_at < 0) first_push_at = ncyc;
            if (wf) full_push_err++;
            if (bus.req_pop == 2'b01) begin
                if (bus.wr_data !== word(0, popped[0])) data_err++;
                popped[0]++;
                pop_cnt[0]++;
            end else if (bus.req_pop == 2'b10) begin
                if (bus.wr_data !== word(1, popped[1])) data_err++;
                popped[1]++;
                pop_cnt[1]++;
            end else begin
                data_err++;
            end
        end else if (bus.req_pop != 2'b00) begin
            data_err++;
        end
        if (bus.cmd_en) begin
            cmds++;
            cmd_at        = ncyc;
            pushes_at_cmd = pushes;
            last_bl       = bus.cmd_bl;
            last_addr     = bus.cmd_byte_addr;
            if (cf) cmd_full_err++;
        end
        if (bus.req_done != 2'b00) begin
            done_cyc++;
            done_at   = ncyc;
            done_bits = done_bits | bus.req_done;
        end
        if (bus.grant != 2'b00 && first_grant == 2'b00) first_grant = bus.grant;
    endtask

    task automatic wait_done(input logic wf, input logic cf, input int budget);
        int n;
        n = 0;
        while (done_cyc == 0 && n < budget) begin
            cyc(wf, cf);
            n++;
        end
        if (done_cyc == 0) fail_now("wait_done");
    endtask

    task automatic wait_grant(input logic wf, input logic cf, input int budget);
        int n;
        n = 0;
        while (first_grant == 2'b00 && n < budget) begin
            cyc(wf, cf);
            n++;
        end
        if (first_grant == 2'b00) fail_now("wait_grant");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, ng, n;
        logic [1:0] prev;
        logic [1:0] gs [4];
        int starts [4];

        vecs[0] = '{2'b01, 30'h0000_0103, 30'h0,         7'd4,   7'd0,   2'b01, 4,  1, 6'd3,  30'h0000_0100};
        vecs[1] = '{2'b10, 30'h0,         30'h0000_2007, 7'd0,   7'd1,   2'b10, 1,  1, 6'd0,  30'h0000_2004};
        vecs[2] = '{2'b11, 30'h0000_0040, 30'h0000_0080, 7'd2,   7'd3,   2'b01, 2,  1, 6'd1,  30'h0000_0040};
        vecs[3] = '{2'b11, 30'h0000_0040, 30'h0000_0080, 7'd2,   7'd3,   2'b10, 3,  1, 6'd2,  30'h0000_0080};
        vecs[4] = '{2'b01, 30'h0000_0500, 30'h0,         7'd0,   7'd0,   2'b01, 0,  0, 6'd0,  30'h0};
        vecs[5] = '{2'b10, 30'h0,         30'h3FFF_FFFF, 7'd0,   7'd100, 2'b10, 64, 1, 6'd63, 30'h3FFF_FFFC};
        vecs[6] = '{2'b01, 30'h0000_1000, 30'h0,         7'd64,  7'd0,   2'b01, 64, 1, 6'd63, 30'h0000_1000};
        vecs[7] = '{2'b10, 30'h0,         30'h0000_0005, 7'd0,   7'd65,  2'b10, 64, 1, 6'd63, 30'h0000_0004};

        popped[0] = 0; popped[1] = 0;
        clr();
        reset              = 1'b1;
        bus.req_valid      = 2'b00;
        bus.req_addr       = '0;
        bus.req_len        = '0;
        bus.req_data       = '0;
        bus.mem_calib_done = 1'b0;
        bus.wr_full        = 1'b0;
        bus.cmd_full       = 1'b0;

        cyc(0, 0);
        cyc(0, 0);
        chk("reset_ctl", {bus.wr_en, bus.req_pop, bus.req_done, bus.grant, bus.busy,
                          bus.cmd_en, bus.cmd_bl, bus.wr_mask, bus.cmd_instr}, 64'd0);
        chk("reset_bus", {bus.cmd_byte_addr, bus.wr_data}, 64'd0);
        reset = 1'b0;

        // Calibration not complete: a pending request must not be granted
        bus.req_addr  = {30'h0, 30'h0000_0100};
        bus.req_len   = {7'd0, 7'd4};
        bus.req_valid = 2'b01;
        bad = 0;
        repeat (4) begin
            cyc(0, 0);
            if (bus.grant != 2'b00 || bus.busy || bus.wr_en) bad++;
        end
        chk("calib_gate_start", bad, 0);
        bus.req_valid      = 2'b00;
        bus.mem_calib_done = 1'b1;

        for (int v = 0; v < 8; v++) begin
            bus.req_addr  = {vecs[v].a1, vecs[v].a0};
            bus.req_len   = {vecs[v].l1, vecs[v].l0};
            bus.req_valid = vecs[v].valid;
            clr();
            wait_done(0, 0, 200);
            bus.req_valid = 2'b00;
            cyc(0, 0);
            cyc(0, 0);
            chk($sformatf("v%0d_grant", v), first_grant, vecs[v].eg);
            chk($sformatf("v%0d_pushes", v), pushes, vecs[v].ep);
            chk($sformatf("v%0d_pop_src", v), pop_cnt[vecs[v].eg[1]], vecs[v].ep);
            chk($sformatf("v%0d_data", v), data_err, 0);
            chk($sformatf("v%0d_cmds", v), cmds, vecs[v].ec);
            chk($sformatf("v%0d_done", v), done_bits, vecs[v].eg);
            chk($sformatf("v%0d_done_len", v), done_cyc, 1);
            if (vecs[v].ec != 0) begin
                chk($sformatf("v%0d_bl", v), last_bl, vecs[v].ebl);
                chk($sformatf("v%0d_addr", v), last_addr, vecs[v].ea);
                chk($sformatf("v%0d_cmd_order", v), pushes_at_cmd, vecs[v].ep);
                chk($sformatf("v%0d_push_to_cmd", v), cmd_at - first_push_at, vecs[v].ep);
                chk($sformatf("v%0d_cmd_to_done", v), done_at - cmd_at, 1);
            end
        end

        // Contention: both requesters valid continuously, len 2 each
        bus.req_addr  = {30'h0000_0080, 30'h0000_0040};
        bus.req_len   = {7'd2, 7'd2};
        bus.req_valid = 2'b11;
        clr();
        ng = 0; n = 0; prev = 2'b00;
        while (ng < 4 && n < 100) begin
            cyc(0, 0);
            n++;
            if (prev == 2'b00 && bus.grant != 2'b00) begin
                gs[ng]     = bus.grant;
                starts[ng] = ncyc;
                ng++;
                if (ng == 4) bus.req_valid = 2'b00;
            end
            prev = bus.grant;
        end
        chk("rr_count", ng, 4);
        if (ng == 4) begin
            chk("rr_g0", gs[0], 2'b01);
            chk("rr_g1", gs[1], 2'b10);
            chk("rr_g2", gs[2], 2'b01);
            chk("rr_g3", gs[3], 2'b10);
            chk("rr_period01", starts[1] - starts[0], 5);
            chk("rr_period12", starts[2] - starts[1], 5);
            chk("rr_period23", starts[3] - starts[2], 5);
        end
        chk("rr_data", data_err, 0);
        clr();
        wait_done(0, 0, 50);
        cyc(0, 0);
        cyc(0, 0);

        // Write backpressure: wr_full for 3 cycles after the 3rd push of 8
        bus.req_addr  = {30'h0, 30'h0000_0200};
        bus.req_len   = {7'd0, 7'd8};
        bus.req_valid = 2'b01;
        clr();
        wait_grant(0, 0, 20);
        cyc(0, 0);
        cyc(0, 0);
        bus.req_valid = 2'b00;
        chk("wf_pre_pushes", pushes, 3);
        repeat (3) cyc(1, 0);
        chk("wf_hold_pushes", pushes, 3);
        wait_done(0, 0, 50);
        cyc(0, 0);
        cyc(0, 0);
        chk("wf_pushes", pushes, 8);
        chk("wf_push_while_full", full_push_err, 0);
        chk("wf_cmd_order", pushes_at_cmd, 8);
        chk("wf_cmds", cmds, 1);
        chk("wf_bl", last_bl, 6'd7);
        chk("wf_addr", last_addr, 30'h0000_0200);
        chk("wf_data", data_err, 0);

        // Command backpressure: cmd_full held through the last push and 5 CMD cycles
        bus.req_addr  = {30'h0000_0333, 30'h0};
        bus.req_len   = {7'd2, 7'd0};
        bus.req_valid = 2'b10;
        clr();
        wait_grant(0, 1, 20);
        cyc(0, 1);
        bus.req_valid = 2'b00;
        repeat (5) cyc(0, 1);
        chk("cf_no_cmd_while_full", cmds, 0);
        wait_done(0, 0, 20);
        cyc(0, 0);
        cyc(0, 0);
        chk("cf_cmds", cmds, 1);
        chk("cf_cmd_while_full", cmd_full_err, 0);
        chk("cf_pushes", pushes, 2);
        chk("cf_bl", last_bl, 6'd1);
        chk("cf_addr", last_addr, 30'h0000_0330);
        chk("cf_done", done_bits, 2'b10);

        // Reset mid-burst after 3 of 6 words, then calibration gating and tie
        bus.req_addr  = {30'h0, 30'h0000_0600};
        bus.req_len   = {7'd0, 7'd6};
        bus.req_valid = 2'b01;
        clr();
        wait_grant(0, 0, 20);
        cyc(0, 0);
        cyc(0, 0);
        chk("rst_pre_pushes", pushes, 3);
        reset              = 1'b1;
        bus.mem_calib_done = 1'b0;
        #1;
        chk("rst_mid_ctl", {bus.wr_en, bus.req_pop, bus.req_done, bus.grant, bus.busy,
                            bus.cmd_en, bus.cmd_bl}, 64'd0);
        chk("rst_mid_bus", {bus.cmd_byte_addr, bus.wr_data}, 64'd0);
        cyc(0, 0);
        cyc(0, 0);
        reset = 1'b0;
        bus.req_addr  = {30'h0000_0800, 30'h0000_0700};
        bus.req_len   = {7'd2, 7'd2};
        bus.req_valid = 2'b11;
        clr();
        bad = 0;
        repeat (6) begin
            cyc(0, 0);
            if (bus.grant != 2'b00 || bus.busy || bus.wr_en) bad++;
        end
        chk("calib_gate_after_rst", bad, 0);
        bus.mem_calib_done = 1'b1;
        clr();
        wait_grant(0, 0, 20);
        bus.req_valid = 2'b00;
        chk("rst_tie_grant", first_grant, 2'b01);
        wait_done(0, 0, 20);
        cyc(0, 0);
        chk("rst_burst_pushes", pushes, 2);
        chk("rst_burst_addr", last_addr, 30'h0000_0700);
        chk("rst_burst_done", done_bits, 2'b01);
        chk("rst_burst_data", data_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ddr_port_write_arbiter.md
# ddr_port_write_arbiter

Shares one MIG user port (command FIFO plus write-data FIFO) between two write requesters: the Mandelbrot point-data path and the frame-clear path. Both previously needed exclusive use of port 0. The block arbitrates round-robin per burst. It streams the granted requester's words into the write FIFO under `wr_full` backpressure, then issues one write command. It sits between the render-side requesters and the port-0 signals of `videoRam`, in the `render_clk` domain.

## Interface
Parameters:
- `BL_MAX`, default 64: maximum burst length in words. Matches the MIG 6-bit `cmd_bl`.
- `ADDR_W`, default 30: byte-address width.

Ports:
- `clk` in 1: render clock. One clock; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 2: bit i set means requester i has a burst pending.
- `req_addr` in 2*ADDR_W: byte addresses. Requester i is at `[i*ADDR_W +: ADDR_W]`.
- `req_len` in 14: burst lengths in words, 7 bits per requester.
- `req_data` in 64: write data, 32 bits per requester. First-word-fall-through.
- `req_pop` out 2: word consumed from requester i this cycle.
- `req_done` out 2: one-cycle pulse when requester i's command has been issued.
- `grant` out 2: one-hot current owner; 0 when no owner.
- `busy` out 1: set in any state other than IDLE or ARB.
- `mem_calib_done` in 1: MIG calibration complete.
- `wr_full` in 1: MIG write FIFO full.
- `cmd_full` in 1: MIG command FIFO full.
- `wr_en` out 1: write-FIFO push.
- `wr_data` out 32: write-FIFO data.
- `wr_mask` out 4: write mask, constant 0.
- `cmd_en` out 1: command push.
- `cmd_instr` out 3: command instruction, constant 3'b000 (write).
- `cmd_bl` out 6: burst length minus 1.
- `cmd_byte_addr` out 30: command address.

## Operation
- **States:** IDLE, ARB, DATA, CMD, DONE.
- **IDLE:** hold until `mem_calib_done`=1, then go to ARB.
- **ARB:** pick a requester only if some `req_valid` bit is set.
  - Only one requester valid: grant it.
  - Both valid: grant the one not served last. `last` resets to 1, so requester 0 wins the first tie.
  - On a grant, latch `req_addr` with bits [1:0] forced to 0, and latch `req_len`, saturated to `BL_MAX`.
  - Latched length 0: go directly to DONE. No data and no command are issued.
  - Otherwise go to DATA with word counter `cnt` = 0.
- **DATA:** on each cycle with `wr_full`=0:
  - assert `wr_en` and `req_pop[g]`;
  - drive `wr_data` = granted requester's `req_data`;
  - increment `cnt`.
  - When `cnt` reaches the latched length (last push), go to CMD.
  - With `wr_full`=1: no push, no pop, counter holds.
- **CMD:** on the first cycle with `cmd_full`=0, pulse `cmd_en` for one cycle with `cmd_bl` = len−1 and `cmd_byte_addr` = latched address, then go to DONE.
- **DONE:** pulse `req_done[g]`, set `last` = g, clear `grant`, return to ARB.
- **Requester contract:** a requester may keep `req_valid` high for back-to-back bursts. It must update its address and length by the cycle after `req_done`.
- **`mem_calib_done` deassert:** only gates IDLE→ARB. A burst already in progress completes.
- **Reset (any state, including mid-burst):**
  - state goes to IDLE;
  - all outputs go to 0;
  - `cnt` = 0, `last` = 1.
  - Words already pushed stay in the MIG FIFO; flushing it is the system reset's job.

## Timing
- **Combinational from current state and inputs:** `wr_en`, `req_pop`, `wr_data`. `wr_en` = (state==DATA) & !`wr_full`.
- **Registered:** `cmd_en`, `cmd_bl`, `cmd_byte_addr`, `req_done`, `grant`, `busy`.
- **ARB to grant:** valid seen in ARB gives `grant` next cycle; the first `wr_en` is in that same cycle (DATA entered).
- **Best-case burst of N words, no backpressure:**
  - N DATA cycles, then one CMD cycle with `cmd_en`, then one DONE cycle with `req_done`;
  - next grant 1 cycle later.
  - Per-burst overhead is 3 cycles beyond N.
- **Command ordering:** `cmd_en` never precedes the last data push, so MIG write-data underrun is impossible.

## Structure
- **Package `ddr_arb_pkg`:** the state enum, `MIG_CMD_WRITE`=3'b000, `MIG_CMD_READ`=3'b001, and the `BL_MAX` default. This package is shared with the port-0 and port-1 controllers.
- **Sub-module `rr_pick2`:** the combinational 2-way round-robin picker. Inputs are `valid[1:0]` and `last`; output is a one-hot grant.

## Test plan
- **Single burst:** `req_valid`=01, addr 0x0000_0103, len 4 → 4 `wr_en` with `req_pop[0]`, then `cmd_en` once with bl=3 and addr 0x100, then `req_done[0]` one cycle later.
- **Contention:** both requesters valid continuously with len 2 → grant sequence 01,10,01,10. Each burst totals 5 cycles (ARB→DONE).
- **Write backpressure:** `wr_full` high for 3 cycles mid len-8 burst → exactly 8 pushes, none while full, and `cmd_en` only after the 8th push.
- **Zero length and saturation:** len 0 → `req_done` with no `wr_en` or `cmd_en`. Len 100 → 64 pushes and bl=63.
- **Command backpressure:** `cmd_full` high for 5 cycles in CMD → `cmd_en` delayed until `cmd_full` falls, and still asserted for exactly one cycle.
- **Reset and calibration:** reset asserted after 3 of 6 words → all outputs 0 the same cycle. After release with `mem_calib_done`=0 → no grant. Raising `mem_calib_done` → requester 0 wins the tie.
